mefsm_seq_ctrl: RTL and testbench

Sequencing controller for the mefsm Mealy FSM (ports clk, rst, a, b). Accepts a parallel WIDTH-bit word over a valid/ready handshake and optionally resets the FSM first. Serializes the word into the FSM input a, LSB first, and captures the Mealy output b in the same cycle. Returns the captured word plus a count of ones over a second valid/ready handshake.

---
 rtl/mefsm_seq_ctrl_pkg.sv | 20 ++
 rtl/mefsm_seq_ctrl_if.sv | 24 ++
 rtl/mefsm_seq_ctrl_cnt.sv | 31 +++
 rtl/mefsm_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_mefsm_seq_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mefsm_seq_ctrl_pkg.sv
// Shared types and width helpers for the mefsm sequencing controller.
package mefsm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FSM_RST = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cw_f(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mefsm_seq_ctrl_if.sv
// Request/result handshake bundle between a word producer/consumer and the controller.
interface mefsm_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = mefsm_seq_pkg::cw_f(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_restart;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_ones;

  modport master (
    output in_valid, in_data, in_restart, out_ready,
    input  in_ready, out_valid, out_data, out_ones
  );

  modport slave (
    input  in_valid, in_data, in_restart, out_ready,
    output in_ready, out_valid, out_data, out_ones
  );
endinterface

// File: rtl/mefsm_seq_ctrl_cnt.sv
// Loadable up/down counter shared by the reset-hold countdown and the bit index.
module mefsm_seq_cnt #(
  parameter int W    = 4,
  parameter int TERM = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  output logic [W-1:0] o_count,
  output logic         o_zero,
  output logic         o_term
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_up ? (r_count + W'(1)) : (r_count - W'(1));
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
  assign o_term  = (r_count == W'(TERM));
endmodule

// File: rtl/mefsm_seq_ctrl.sv
// Serializes a word into the mefsm input a (LSB first) and captures its Mealy output b.
module mefsm_seq_ctrl
  import mefsm_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RST_CYCLES = 2,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  mefsm_seq_ctrl_if.slave  bus,
  output logic             fsm_rst,
  output logic             fsm_a,
  input  logic             fsm_b,
  output logic             busy
);
  // One counter covers both RST_CYCLES-1 and WIDTH-1.
  localparam int KW = max_f(cw_f(WIDTH), cw_f(RST_CYCLES));

  state_t           r_state;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_ones;
  logic             r_out_valid;
  logic             r_fsm_rst;
  logic             r_fsm_a;

  logic             w_accept;
  logic             w_cnt_load;
  logic [KW-1:0]    w_cnt_val;
  logic             w_cnt_en;
  logic             w_cnt_up;
  logic [KW-1:0]    w_cnt;
  logic             w_zero;
  logic             w_term;
  logic [WIDTH-1:0] w_sel;

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_en   = 1'b0;
    w_cnt_up   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_load = w_accept;
        w_cnt_val  = bus.in_restart ? KW'(RST_CYCLES - 1) : '0;
      end
      ST_FSM_RST: begin
        w_cnt_load = w_zero;
        w_cnt_en   = !w_zero;
      end
      ST_SHIFT: begin
        w_cnt_en = 1'b1;
        w_cnt_up = 1'b1;
      end
      default: begin
        w_cnt_load = 1'b0;
      end
    endcase
  end

  mefsm_seq_cnt #(
    .W    (KW),
    .TERM (WIDTH - 1)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .i_up       (w_cnt_up),
    .o_count    (w_cnt),
    .o_zero     (w_zero),
    .o_term     (w_term)
  );

  // One-hot write enable for the result bit addressed by the current index.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
    assign w_sel[gi] = (w_cnt == KW'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_sh        <= '0;
      r_out_data  <= '0;
      r_ones      <= '0;
      r_out_valid <= 1'b0;
      r_fsm_rst   <= 1'b1;
      r_fsm_a     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fsm_rst <= 1'b0;
          if (w_accept) begin
            r_sh   <= {1'b0, bus.in_data};
            r_ones <= '0;
            if (bus.in_restart) begin
              r_state   <= ST_FSM_RST;
              r_fsm_rst <= 1'b1;
              r_fsm_a   <= 1'b0;
            end else begin
              r_state <= ST_SHIFT;
              r_fsm_a <= bus.in_data[0];
            end
          end
        end
        ST_FSM_RST: begin
          if (w_zero) begin
            r_fsm_rst <= 1'b0;
            r_fsm_a   <= r_sh[0];
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_out_data <= (r_out_data & ~w_sel) | (w_sel & {WIDTH{fsm_b}});
          r_ones     <= r_ones + CW'(fsm_b);
          r_sh       <= r_sh >> 1;
          // r_sh[1] is the bit that goes out on the next cycle.
          r_fsm_a    <= w_term ? 1'b0 : r_sh[1];
          if (w_term) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ones  = r_ones;
  assign fsm_rst       = r_fsm_rst;
  assign fsm_a         = r_fsm_a;
  assign busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mefsm_seq_ctrl.sv
// Directed bench for mefsm_seq_ctrl: stubbed and reference-Mealy fsm_b sources.
module tb_mefsm_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int RSTC  = 2;
  localparam int CW    = $clog2(WIDTH + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       fsm_rst;
  logic       fsm_a;
  logic       fsm_b;
  logic       busy;
  logic [1:0] mode;
  logic       mq;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int rh;

  always #5 clk = ~clk;

  mefsm_seq_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  mefsm_seq_ctrl #(
    .WIDTH      (WIDTH),
    .RST_CYCLES (RSTC),
    .CW         (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fsm_rst (fsm_rst),
    .fsm_a   (fsm_a),
    .fsm_b   (fsm_b),
    .busy    (busy)
  );

  // Reference Mealy machine: q toggles on every a=1, b = a & q.
  always_ff @(posedge clk) begin
    if (fsm_rst) mq <= 1'b0;
    else         mq <= mq ^ fsm_a;
  end

  assign fsm_b = (mode == 2'd0) ? fsm_a :
                 (mode == 2'd1) ? 1'b1  : (mq & fsm_a);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
  endtask

  task automatic accept(input logic [WIDTH-1:0] d, input logic rs);
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_restart = rs;
    tick;
    bus.in_valid   = 1'b0;
    bus.in_restart = 1'b0;
  endtask

  // Counts samples from the accept cycle until out_valid is seen.
  task automatic wait_done(output int l, output int r);
    l = 1;
    r = int'(fsm_rst);
    while (!bus.out_valid && l < 200) begin
      tick;
      l++;
      r += int'(fsm_rst);
    end
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    mode = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_restart = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick;

    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_fsm_rst",   32'(fsm_rst),       32'd1);
    chk("rst_fsm_a",     32'(fsm_a),         32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'h00);
    chk("rst_out_ones",  32'(bus.out_ones),  32'd0);

    rst = 1'b1;
    chk("first_idle_fsm_rst", 32'(fsm_rst), 32'd1);
    tick;
    chk("fsm_rst_release", 32'(fsm_rst), 32'd0);

    // Plain word, echo stub
    mode = 2'd0;
    accept(8'hA5, 1'b0);
    wait_done(lat, rh);
    chk("a5_latency", 32'(lat),          32'd9);
    chk("a5_fsm_rst", 32'(rh),           32'd0);
    chk("a5_data",    32'(bus.out_data), 32'hA5);
    chk("a5_ones",    32'(bus.out_ones), 32'd4);
    chk("a5_fsm_a",   32'(fsm_a),        32'd0);
    drain("a5");

    // Restart with constant-one stub
    mode = 2'd1;
    accept(8'h00, 1'b1);
    wait_done(lat, rh);
    chk("rs_fsm_rst_cycles", 32'(rh),           32'd2);
    chk("rs_latency",        32'(lat),          32'd11);
    chk("rs_data",           32'(bus.out_data), 32'hFF);
    chk("rs_ones",           32'(bus.out_ones), 32'd8);
    drain("rs");

    // Backpressure: result held, second request ignored
    mode = 2'd0;
    accept(8'h3C, 1'b0);
    wait_done(lat, rh);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data",  32'(bus.out_data),  32'h3C);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      tick;
    end
    bus.in_valid = 1'b0;
    drain("bp");
    chk("bp_out_valid_low", 32'(bus.out_valid), 32'd0);
    chk("bp_data_kept",     32'(bus.out_data),  32'h3C);
    chk("bp_in_ready_back", 32'(bus.in_ready),  32'd1);

    // Reset in the 4th SHIFT cycle
    accept(8'hFF, 1'b0);
    repeat (3) tick;
    chk("mid_busy", 32'(busy),          32'd1);
    chk("mid_ones", 32'(bus.out_ones),  32'd3);
    rst = 1'b0;
    tick;
    chk("mid_rst_busy",      32'(busy),          32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_fsm_rst",   32'(fsm_rst),       32'd1);
    chk("mid_rst_fsm_a",     32'(fsm_a),         32'd0);
    chk("mid_rst_ones",      32'(bus.out_ones),  32'd0);
    rst = 1'b1;
    tick;
    accept(8'h0F, 1'b0);
    wait_done(lat, rh);
    chk("post_rst_data", 32'(bus.out_data), 32'h0F);
    chk("post_rst_ones", 32'(bus.out_ones), 32'd4);
    drain("post_rst");

    // Back-to-back with out_ready tied high
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'h01;
    tick;
    bus.in_data    = 8'h80;
    wait_done(lat, rh);
    chk("b2b_first_data", 32'(bus.out_data), 32'h01);
    chk("b2b_first_ones", 32'(bus.out_ones), 32'd1);
    tick;
    chk("b2b_accept_slot", 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    wait_done(lat, rh);
    chk("b2b_second_lat",  32'(lat),          32'd9);
    chk("b2b_second_data", 32'(bus.out_data), 32'h80);
    chk("b2b_second_ones", 32'(bus.out_ones), 32'd1);
    tick;
    bus.out_ready = 1'b0;
    chk("b2b_done_idle", 32'(busy), 32'd0);

    // Reference Mealy machine, history carried across words
    mode = 2'd2;
    accept(8'h3C, 1'b1);
    wait_done(lat, rh);
    chk("m1_data", 32'(bus.out_data), 32'h28);
    chk("m1_ones", 32'(bus.out_ones), 32'd2);
    drain("m1");
    accept(8'h3C, 1'b0);
    wait_done(lat, rh);
    chk("m2_data", 32'(bus.out_data), 32'h28);
    chk("m2_lat",  32'(lat),          32'd9);
    drain("m2");
    accept(8'h01, 1'b0);
    wait_done(lat, rh);
    chk("m3_data", 32'(bus.out_data), 32'h00);
    chk("m3_ones", 32'(bus.out_ones), 32'd0);
    drain("m3");
    accept(8'h3C, 1'b0);
    wait_done(lat, rh);
    chk("m4_data", 32'(bus.out_data), 32'h14);
    chk("m4_ones", 32'(bus.out_ones), 32'd2);
    drain("m4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
